i2c_cmd_queue: RTL and testbench

- Command sequencer directly upstream of the i2c master/slave top.
- Buffers host transactions (read or write, single or multi-byte) in a small FIFO and issues them one at a time on the master's strobe interface.
- Waits for master completion, with a watchdog, then returns one response per command: read data plus error flag.
- Gives the host a decoupled valid/ready interface, so firmware never times the master's strobes.

---
 rtl/i2c_cmd_queue_pkg.sv | 37 +++
 rtl/i2c_cmd_queue_fifo.sv | 51 +++++
 rtl/i2c_cmd_queue.sv | 199 +++++++++++++++++++
 tb/tb_i2c_cmd_queue.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cmd_queue_pkg.sv
// Shared types and packed-entry layout for the i2c command queue.
// A FIFO entry is packed as {read, multi, chip_addr[6:0], reg_addr, wdata},
// with wdata in the least significant bits.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam int CHIP_W = 7;

    // Total width of one packed command entry.
    function automatic int cmd_w(input int reg_w, input int data_w);
        return 2 + CHIP_W + reg_w + data_w;
    endfunction

    // Field offsets inside a packed command entry.
    function automatic int reg_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int chip_lsb(input int reg_w, input int data_w);
        return data_w + reg_w;
    endfunction

    function automatic int multi_bit(input int reg_w, input int data_w);
        return data_w + reg_w + CHIP_W;
    endfunction

    function automatic int read_bit(input int reg_w, input int data_w);
        return data_w + reg_w + CHIP_W + 1;
    endfunction

endpackage

// File: rtl/i2c_cmd_queue_fifo.sv
// Command FIFO: DEPTH entries of W bits, registered pointers with a wrap bit.
// Read data is the head entry, visible the cycle after it was written.
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Full/empty come only from registered pointers; a push while full is refused.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care while the entry is not valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/i2c_cmd_queue.sv
// Command sequencer in front of the i2c master: buffers host commands, issues
// them one at a time as single-cycle strobes, waits for done with a watchdog,
// and returns one response (read data + error flag) per command.
// Optional macro I2C_CMDQ_STATS_EN builds saturating ok/error response counters;
// without it stat_ok_cnt and stat_err_cnt are tied to 0.
//
// Handshakes: both host channels are valid/ready. A transfer happens on a cycle
// where valid && ready are both high at the rising clock edge; the offering side
// holds its payload stable until that cycle. cmd_ready and rsp_valid depend on
// registered state only.
module i2c_cmd_queue
    import i2c_pkg::*;
#(
    parameter int ADDR_BYTES     = 1,
    parameter int DATA_BYTES     = 2,
    parameter int REG_ADDR_WIDTH = 8 * ADDR_BYTES,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_read,
    input  logic                      cmd_multi,
    input  logic [6:0]                cmd_chip_addr,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_reg_addr,
    input  logic [8*DATA_BYTES-1:0]   cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [8*DATA_BYTES-1:0]   rsp_rdata,
    output logic                      rsp_err,
    output logic                      m_enable,
    output logic [6:0]                m_chip_addr,
    output logic [REG_ADDR_WIDTH-1:0] m_reg_addr,
    output logic [8*DATA_BYTES-1:0]   m_data_in,
    output logic                      m_write_en,
    output logic                      m_write_mode,
    output logic                      m_read_en,
    input  logic                      m_done,
    input  logic [8*DATA_BYTES-1:0]   m_data_out,
    output logic [15:0]               stat_ok_cnt,
    output logic [15:0]               stat_err_cnt
);

    localparam int DW        = 8 * DATA_BYTES;
    localparam int RAW       = REG_ADDR_WIDTH;
    localparam int CMD_W     = cmd_w(RAW, DW);
    localparam int REG_LSB   = reg_lsb(DW);
    localparam int CHIP_LSB  = chip_lsb(RAW, DW);
    localparam int MULTI_BIT = multi_bit(RAW, DW);
    localparam int READ_BIT  = read_bit(RAW, DW);
    localparam int TW        = $clog2(TIMEOUT_CYCLES);
    // The abort fires on the edge where the timer would reach TIMEOUT_CYCLES-1,
    // so the response appears TIMEOUT_CYCLES cycles after the strobe.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    state_t            state;
    state_t            next_state;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CMD_W-1:0]  head;
    logic [TW-1:0]     timer;
    logic              op_read;
    logic              op_multi;
    logic [6:0]        op_chip;
    logic [RAW-1:0]    op_reg;
    logic [DW-1:0]     op_wdata;

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .pop   (pop),
        .wdata ({cmd_read, cmd_multi, cmd_chip_addr, cmd_reg_addr, cmd_wdata}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign cmd_ready    = !full;
    assign m_enable     = en;
    assign m_chip_addr  = op_chip;
    assign m_reg_addr   = op_reg;
    assign m_data_in    = op_wdata;
    assign m_write_mode = op_multi;
    assign m_write_en   = (state == ISSUE) && !op_read;
    assign m_read_en    = (state == ISSUE) && op_read;
    assign rsp_valid    = (state == RESP);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and FIFO pop decision.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (en && !empty) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (m_done || (timer == TIMER_LAST)) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand latch, watchdog timer and response capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_read   <= 1'b0;
            op_multi  <= 1'b0;
            op_chip   <= '0;
            op_reg    <= '0;
            op_wdata  <= '0;
            timer     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (pop) begin
                op_read  <= head[READ_BIT];
                op_multi <= head[MULTI_BIT];
                op_chip  <= head[CHIP_LSB +: 7];
                op_reg   <= head[REG_LSB +: RAW];
                op_wdata <= head[0 +: DW];
            end
            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT_DONE) begin
                if (m_done) begin
                    rsp_rdata <= op_read ? m_data_out : '0;
                    rsp_err   <= 1'b0;
                end else if (timer == TIMER_LAST) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                    timer     <= timer + TIMER_ONE;
                end else begin
                    timer <= timer + TIMER_ONE;
                end
            end
        end
    end

`ifdef I2C_CMDQ_STATS_EN
    logic        resp_enter;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;

    assign resp_enter   = (state == WAIT_DONE) && (next_state == RESP);
    assign stat_ok_cnt  = ok_cnt;
    assign stat_err_cnt = err_cnt;

    // Saturating counters of completed and aborted commands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else if (resp_enter) begin
            if (m_done) begin
                if (ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
            end else begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign stat_ok_cnt  = 16'd0;
    assign stat_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Directed bench for i2c_cmd_queue: one instance with the default watchdog for
// the functional tests and one with TIMEOUT_CYCLES=8 for the abort test.
module tb_i2c_cmd_queue;

    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          en;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic          cmd_multi;
    logic [6:0]    cmd_chip_addr;
    logic [7:0]    cmd_reg_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          m_enable;
    logic [6:0]    m_chip_addr;
    logic [7:0]    m_reg_addr;
    logic [DW-1:0] m_data_in;
    logic          m_write_en;
    logic          m_write_mode;
    logic          m_read_en;
    logic          m_done;
    logic [DW-1:0] m_data_out;
    logic [15:0]   stat_ok_cnt;
    logic [15:0]   stat_err_cnt;

    logic          t_cmd_valid;
    logic          t_cmd_ready;
    logic          t_rsp_valid;
    logic          t_rsp_ready;
    logic [DW-1:0] t_rsp_rdata;
    logic          t_rsp_err;
    logic          t_m_enable;
    logic [6:0]    t_m_chip_addr;
    logic [7:0]    t_m_reg_addr;
    logic [DW-1:0] t_m_data_in;
    logic          t_m_write_en;
    logic          t_m_write_mode;
    logic          t_m_read_en;
    logic          t_m_done;
    logic [DW-1:0] t_m_data_out;
    logic [15:0]   t_stat_ok_cnt;
    logic [15:0]   t_stat_err_cnt;

    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    exp_q[$];

    i2c_cmd_queue #(
        .DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_read      (cmd_read),
        .cmd_multi     (cmd_multi),
        .cmd_chip_addr (cmd_chip_addr),
        .cmd_reg_addr  (cmd_reg_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .m_enable      (m_enable),
        .m_chip_addr   (m_chip_addr),
        .m_reg_addr    (m_reg_addr),
        .m_data_in     (m_data_in),
        .m_write_en    (m_write_en),
        .m_write_mode  (m_write_mode),
        .m_read_en     (m_read_en),
        .m_done        (m_done),
        .m_data_out    (m_data_out),
        .stat_ok_cnt   (stat_ok_cnt),
        .stat_err_cnt  (stat_err_cnt)
    );

    i2c_cmd_queue #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (8)
    ) dut_to (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .cmd_valid     (t_cmd_valid),
        .cmd_ready     (t_cmd_ready),
        .cmd_read      (cmd_read),
        .cmd_multi     (cmd_multi),
        .cmd_chip_addr (cmd_chip_addr),
        .cmd_reg_addr  (cmd_reg_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (t_rsp_valid),
        .rsp_ready     (t_rsp_ready),
        .rsp_rdata     (t_rsp_rdata),
        .rsp_err       (t_rsp_err),
        .m_enable      (t_m_enable),
        .m_chip_addr   (t_m_chip_addr),
        .m_reg_addr    (t_m_reg_addr),
        .m_data_in     (t_m_data_in),
        .m_write_en    (t_m_write_en),
        .m_write_mode  (t_m_write_mode),
        .m_read_en     (t_m_read_en),
        .m_done        (t_m_done),
        .m_data_out    (t_m_data_out),
        .stat_ok_cnt   (t_stat_ok_cnt),
        .stat_err_cnt  (t_stat_err_cnt)
    );

    // Clock and hard time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL time_limit: simulation did not finish, got running required finished");
        $fatal(1, "time limit");
    end

    // Scoreboard compare.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command to the main instance for one cycle.
    task automatic push(input logic rd, input logic multi, input logic [6:0] chip,
                        input logic [7:0] rg, input logic [DW-1:0] wd);
        cmd_read      = rd;
        cmd_multi     = multi;
        cmd_chip_addr = chip;
        cmd_reg_addr  = rg;
        cmd_wdata     = wd;
        cmd_valid     = 1'b1;
        tick();
        cmd_valid     = 1'b0;
    endtask

    // Wait (bounded) until the main instance raises a strobe.
    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        while (!(m_write_en || m_read_en) && n < 20) begin
            tick();
            n++;
        end
        if (!(m_write_en || m_read_en)) check({tag, "_strobe_wait"}, 32'd0, 32'd1);
    endtask

    initial begin
        int cnt;
        int first;
        logic [7:0] e;

        reset = 1'b0;
        en = 1'b1;
        cmd_valid = 1'b0;
        cmd_read = 1'b0;
        cmd_multi = 1'b0;
        cmd_chip_addr = '0;
        cmd_reg_addr = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        m_done = 1'b0;
        m_data_out = '0;
        t_cmd_valid = 1'b0;
        t_rsp_ready = 1'b0;
        t_m_done = 1'b0;
        t_m_data_out = '0;

        // Reset values.
        repeat (3) tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_write_en", 32'(m_write_en), 32'd0);
        check("rst_read_en", 32'(m_read_en), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_chip", 32'(m_chip_addr), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_m_enable_hi", 32'(m_enable), 32'd1);
        en = 1'b0;
        #1;
        check("rst_m_enable_lo", 32'(m_enable), 32'd0);
        check("rst_stat_ok", 32'(stat_ok_cnt), 32'd0);
        en = 1'b1;
        tick();
        reset = 1'b1;
        tick();

        // Single write: strobe two cycles after the push, one cycle wide.
        push(1'b0, 1'b0, 7'h50, 8'h10, 16'hBEEF);
        check("wr_pop_cycle_no_strobe", 32'(m_write_en), 32'd0);
        tick();
        check("wr_strobe", 32'(m_write_en), 32'd1);
        check("wr_no_read", 32'(m_read_en), 32'd0);
        check("wr_mode", 32'(m_write_mode), 32'd0);
        check("wr_chip", 32'(m_chip_addr), 32'h50);
        check("wr_reg", 32'(m_reg_addr), 32'h10);
        check("wr_data", 32'(m_data_in), 32'hBEEF);
        tick();
        check("wr_strobe_one_cycle", 32'(m_write_en), 32'd0);
        repeat (18) tick();
        check("wr_chip_stable", 32'(m_chip_addr), 32'h50);
        m_done = 1'b1;
        m_data_out = 16'hDEAD;
        tick();
        m_done = 1'b0;
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("wr_rsp_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("wr_rsp_drop", 32'(rsp_valid), 32'd0);

        // Read: data returned one cycle after m_done.
        push(1'b1, 1'b0, 7'h21, 8'h03, 16'h0000);
        tick();
        check("rd_strobe", 32'(m_read_en), 32'd1);
        check("rd_no_write", 32'(m_write_en), 32'd0);
        check("rd_chip", 32'(m_chip_addr), 32'h21);
        tick();
        m_data_out = 16'h1234;
        m_done = 1'b1;
        check("rd_no_rsp_yet", 32'(rsp_valid), 32'd0);
        tick();
        m_done = 1'b0;
        m_data_out = 16'h0000;
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_rdata", 32'(rsp_rdata), 32'h1234);
        check("rd_rsp_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Backpressure: fill with en=0, fifth push refused.
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({1'(i % 2), 7'(8'h11 + i)});
            push(1'b0, 1'(i % 2), 7'(8'h11 + i), 8'(8'h40 + i), 16'(16'h1000 + i));
            if (i == 2) check("bp_ready_after_3", 32'(cmd_ready), 32'd1);
            if (i == 3) check("bp_full_after_4", 32'(cmd_ready), 32'd0);
            if (i == 4) check("bp_full_after_5", 32'(cmd_ready), 32'd0);
        end
        check("bp_no_strobe_en0", 32'(m_write_en), 32'd0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_strobe("bp");
            e = exp_q.pop_front();
            check("bp_order_chip", 32'(m_chip_addr), 32'(e[6:0]));
            check("bp_order_mode", 32'(m_write_mode), 32'(e[7]));
            if (i == 0) check("bp_ready_after_pop", 32'(cmd_ready), 32'd1);
            tick();
            m_done = 1'b1;
            tick();
            m_done = 1'b0;
            if (i == 0) begin
                cnt = 0;
                for (int k = 0; k < 6; k++) begin
                    tick();
                    if (m_write_en || m_read_en) cnt++;
                end
                check("bp_stall_strobes", 32'(cnt), 32'd0);
                check("bp_rsp_held", 32'(rsp_valid), 32'd1);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end

        // m_done while idle produces nothing.
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        check("idle_done_ignored", 32'(rsp_valid), 32'd0);
`ifdef I2C_CMDQ_STATS_EN
        check("stat_ok_six", 32'(stat_ok_cnt), 32'd6);
        check("stat_err_zero", 32'(stat_err_cnt), 32'd0);
`else
        check("stat_ok_tied", 32'(stat_ok_cnt), 32'd0);
        check("stat_err_tied", 32'(stat_err_cnt), 32'd0);
`endif

        // Reset mid-transaction with two entries still queued.
        cmd_read = 1'b0;
        cmd_multi = 1'b0;
        cmd_valid = 1'b1;
        cmd_chip_addr = 7'h31;
        tick();
        cmd_chip_addr = 7'h32;
        tick();
        cmd_chip_addr = 7'h33;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_chip_before_rst", 32'(m_chip_addr), 32'h31);
        reset = 1'b0;
        #1;
        check("mid_rst_write_en", 32'(m_write_en), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_chip", 32'(m_chip_addr), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (m_write_en || m_read_en || rsp_valid) cnt++;
        end
        check("mid_after_rst_quiet", 32'(cnt), 32'd0);
`ifdef I2C_CMDQ_STATS_EN
        check("stat_ok_cleared", 32'(stat_ok_cnt), 32'd0);
`endif

        // Watchdog abort with TIMEOUT_CYCLES=8.
        cmd_read = 1'b1;
        cmd_multi = 1'b0;
        cmd_chip_addr = 7'h44;
        cmd_reg_addr = 8'h55;
        t_m_data_out = 16'hA5A5;
        t_cmd_valid = 1'b1;
        tick();
        t_cmd_valid = 1'b0;
        tick();
        check("to_strobe", 32'(t_m_read_en), 32'd1);
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (t_rsp_valid && first == 0) first = k;
        end
        check("to_latency", 32'(first), 32'd8);
        check("to_err", 32'(t_rsp_err), 32'd1);
        check("to_rdata", 32'(t_rsp_rdata), 32'd0);
`ifdef I2C_CMDQ_STATS_EN
        check("to_stat_err", 32'(t_stat_err_cnt), 32'd1);
        check("to_stat_ok", 32'(t_stat_ok_cnt), 32'd0);
`endif
        t_rsp_ready = 1'b1;
        tick();
        t_rsp_ready = 1'b0;
        check("to_rsp_drop", 32'(t_rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
